// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Each granted byte is sent as a complete frame before the next grant is made.
module uart_tx_arbiter #(
    parameter int unsigned CLOCKS_PER_BAUD = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid0,
    input  logic [7:0] i_data0,
    output logic       o_ready0,
    input  logic       i_valid1,
    input  logic [7:0] i_data1,
    output logic       o_ready1,
    output logic       o_uart,
    output logic       o_busy,
    output logic       o_owner
);

    localparam int unsigned CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          last_served;
    logic          baud_done;
    logic          grant0;
    logic          grant1;

    assign baud_done = (baud_cnt == '0);

    // Grants are gated by reset so no handshake is seen while the block is held in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !i_reset) begin
            if (i_valid0 && (!i_valid1 || last_served)) begin
                grant0 = 1'b1;
            end else if (i_valid1) begin
                grant1 = 1'b1;
            end
        end
    end

    assign o_ready0 = grant0;
    assign o_ready1 = grant1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            o_uart      <= 1'b1;
            o_busy      <= 1'b0;
            o_owner     <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        shreg       <= grant1 ? i_data1 : i_data0;
                        o_owner     <= grant1;
                        last_served <= grant1;
                        o_uart      <= 1'b0;
                        o_busy      <= 1'b1;
                        baud_cnt    <= BAUD_LAST;
                        state       <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        o_uart   <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_LAST;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_idx == 3'd7) begin
                            o_uart <= 1'b1;
                            state  <= STOP;
                        end else begin
                            // Shift register is pre-shifted, so bit 0 is always the next bit out.
                            bit_idx <= bit_idx + 3'd1;
                            o_uart  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmit line between two byte-stream requesters with round-robin arbitration.
- Requester 0 is the receive-echo path; requester 1 is the on-board status/message source.
- Each accepted byte is serialised as a complete frame before the next grant is made.
- Sits between the fabric byte producers and the o_uart pad; replaces the direct wire from input to output.

Parameters:
- CLOCKS_PER_BAUD, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2 to 65535.

Ports:
- i_clk  input  1  system clock; all logic is rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid0  input  1  requester 0 has a byte to send.
- i_data0  input  8  requester 0 byte; must be stable while i_valid0 is high.
- o_ready0  output  1  requester 0 byte accepted this cycle when i_valid0 is also high.
- i_valid1  input  1  requester 1 has a byte to send.
- i_data1  input  8  requester 1 byte; must be stable while i_valid1 is high.
- o_ready1  output  1  requester 1 byte accepted this cycle when i_valid1 is also high.
- o_uart  output  1  serial TX line; idle is high.
- o_busy  output  1  a frame is in progress.
- o_owner  output  1  requester whose frame is currently on the line; valid only while o_busy is high.

Behaviour:
- Reset (asynchronous, immediate):
  - o_uart=1, o_busy=0, o_owner=0, state=IDLE.
  - Baud counter and bit index are cleared.
  - The last-served pointer is set to 1, so requester 0 wins the first tie.
  - Reset mid-frame aborts the frame: the line returns high at once and the in-flight byte is discarded, never resumed.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - o_ready0 and o_ready1 are combinational: at most one is high, and only in IDLE.
  - Only one valid high: that requester is readied.
  - Both valid high: ready goes to the requester that is not the last-served one.
  - A transfer is valid & ready in the same cycle. On transfer:
    - latch the byte into the shift register;
    - set o_owner and the last-served pointer to the winner;
    - the next state is START.
  - No valid: stay in IDLE with o_uart=1.
- START: o_uart=0 for CLOCKS_PER_BAUD cycles.
- DATA:
  - 8 bits, LSB first, each held for exactly CLOCKS_PER_BAUD cycles.
  - A 3-bit index tracks the bit position; the shift register shifts right after each bit.
- STOP: o_uart=1 for CLOCKS_PER_BAUD cycles, then IDLE.
- o_uart is registered. The first START cycle appears on the line the cycle after the transfer.
- Frame timing:
  - A frame occupies exactly 10*CLOCKS_PER_BAUD cycles with o_busy high.
  - Back-to-back frames have exactly one IDLE cycle between them (arbitration cycle, o_uart=1).
  - Frame period is therefore 10*CLOCKS_PER_BAUD+1 cycles.
- Baud counter:
  - Width is $clog2(CLOCKS_PER_BAUD).
  - Loads CLOCKS_PER_BAUD-1 on entry to each bit and decrements to 0.
  - Reaching 0 advances the bit, with no off-by-one drift across the frame.
- Valid rules:
  - Deasserting valid before acceptance is legal; no byte is taken.
  - A valid raised while o_busy=1 waits; it is never dropped.
  - Input data changes while the frame is active have no effect; the byte is already latched.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1...
  - No requester waits more than one frame period plus one cycle after the line goes idle.

Test Plan:
- CLOCKS_PER_BAUD=4. Assert reset mid-stream -> o_uart=1, o_busy=0, o_ready0=o_ready1=0 in the same cycle, asynchronously.
- Requester 0 sends 0x55, requester 1 idle -> o_ready0 pulses for 1 cycle. Then o_uart reads 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop), each bit exactly 4 cycles. o_busy is high for 40 cycles and o_owner=0.
- Both valid from reset with 0xA5 (req 0) and 0x3C (req 1) -> req 0 goes first, then req 1 after exactly 1 idle cycle. Frame starts are 41 cycles apart and o_owner goes 0 then 1.
- Both held valid for 4 bytes each -> owner sequence 0,1,0,1,0,1,0,1 with no byte lost or duplicated. A decoding monitor reproduces both streams in order.
- Req 1 raises valid in the middle of a req-0 frame, then req 1 drops valid 5 cycles later -> no transfer for req 1. The line idles after the req-0 frame completes.
- Reset asserted at bit 3 of a 0xFF frame, released, then req 0 sends 0x00 -> the aborted frame is not resumed. The new frame is a clean 0x00 with correct timing.
